// File: rtl/reg_ring_inst_iface.sv
// Register-ring front end for a multi-instance block: decode, hold for the local register SM, return with timeout.
// Define REG_RING_IFACE_ERR_CNT_EN to add the saturating error counter answered at index NUM_REGS_USED-1.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module reg_ring_inst_iface #(
    parameter int unsigned UDP_REG_SRC_WIDTH   = 2,
    parameter int unsigned BLOCK_ADDR_WIDTH    = 17,
    parameter logic [`UDP_REG_ADDR_WIDTH-BLOCK_ADDR_WIDTH-1:0] BLOCK_TAG = '0,
    parameter int unsigned INST_REG_ADDR_WIDTH = 8,
    parameter int unsigned NUM_INSTANCES       = 8,
    parameter int unsigned NUM_REGS_USED       = 17,
    parameter int unsigned TIMEOUT_CYCLES      = 255,
    parameter logic [`CPCI_NF2_DATA_WIDTH-1:0] ERR_DATA = 32'hdead_beef,
    localparam int unsigned INST_WIDTH = (NUM_INSTANCES > 1) ? $clog2(NUM_INSTANCES) : 1,
    localparam int unsigned ADDR_WIDTH = (NUM_REGS_USED > 1) ? $clog2(NUM_REGS_USED) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                reg_req_in,
    input  logic                                reg_ack_in,
    input  logic                                reg_rd_wr_L_in,
    input  logic [`UDP_REG_ADDR_WIDTH-1:0]      reg_addr_in,
    input  logic [`CPCI_NF2_DATA_WIDTH-1:0]     reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0]        reg_src_in,
    output logic                                reg_req_out,
    output logic                                reg_ack_out,
    output logic                                reg_rd_wr_L_out,
    output logic [`UDP_REG_ADDR_WIDTH-1:0]      reg_addr_out,
    output logic [`CPCI_NF2_DATA_WIDTH-1:0]     reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0]        reg_src_out,
    output logic                                req_in_progress,
    output logic                                reg_rd_wr_L_held,
    output logic [`CPCI_NF2_DATA_WIDTH-1:0]     reg_data_held,
    output logic [ADDR_WIDTH-1:0]               addr,
    output logic [INST_WIDTH-1:0]               inst_addr,
    input  logic                                result_ready,
    input  logic [`CPCI_NF2_DATA_WIDTH-1:0]     reg_result,
    output logic                                req_abort
);

    localparam int unsigned AW     = `UDP_REG_ADDR_WIDTH;
    localparam int unsigned DW     = `CPCI_NF2_DATA_WIDTH;
    localparam int unsigned TAG_W  = AW - BLOCK_ADDR_WIDTH;
    localparam int unsigned INST_F = BLOCK_ADDR_WIDTH - INST_REG_ADDR_WIDTH;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t                       state_q, state_d;
    logic                         req_out_q, req_out_d, ack_out_q, ack_out_d, rw_out_q, rw_out_d;
    logic [AW-1:0]                addr_out_q, addr_out_d;
    logic [DW-1:0]                data_out_q, data_out_d;
    logic [UDP_REG_SRC_WIDTH-1:0] src_out_q, src_out_d;
    logic                         in_prog_q, in_prog_d, abort_q, abort_d;
    logic                         held_req_q, held_req_d, held_rw_q, held_rw_d;
    logic [AW-1:0]                held_addr_q, held_addr_d;
    logic [DW-1:0]                held_data_q, held_data_d;
    logic [UDP_REG_SRC_WIDTH-1:0] held_src_q, held_src_d;
    logic [CNT_W-1:0]             tmo_cnt_q, tmo_cnt_d;

    logic [TAG_W-1:0]               tag_c;
    logic [INST_REG_ADDR_WIDTH-1:0] reg_idx_c;
    logic [INST_F-1:0]              inst_idx_c;
    logic tag_hit_c, addr_good_c, fwd_hit_c, bad_hit_c, local_hit_c, tmo_hit_c;

    // Request decode against tag, register and instance limits
    assign tag_c       = reg_addr_in[AW-1:BLOCK_ADDR_WIDTH];
    assign reg_idx_c   = reg_addr_in[INST_REG_ADDR_WIDTH-1:0];
    assign inst_idx_c  = reg_addr_in[BLOCK_ADDR_WIDTH-1:INST_REG_ADDR_WIDTH];
    assign tag_hit_c   = (tag_c == BLOCK_TAG);
    assign addr_good_c = (32'(reg_idx_c) < NUM_REGS_USED) && (32'(inst_idx_c) < NUM_INSTANCES);
    assign bad_hit_c   = reg_req_in && tag_hit_c && !addr_good_c;
    assign fwd_hit_c   = reg_req_in && tag_hit_c && addr_good_c && !local_hit_c;
    assign tmo_hit_c   = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef REG_RING_IFACE_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q;
    logic             err_inc_c, err_clr_c;

    assign local_hit_c = reg_req_in && tag_hit_c && addr_good_c &&
                         (32'(reg_idx_c) == NUM_REGS_USED - 1);
    assign err_inc_c   = ((state_q == ST_IDLE) && bad_hit_c) ||
                         ((state_q == ST_WAIT) && !result_ready && tmo_hit_c);
    assign err_clr_c   = (state_q == ST_IDLE) && local_hit_c && !reg_rd_wr_L_in;

    // Saturating count of bad-address hits and timeouts; a write to its index clears it
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_cnt_q <= '0;
        end else if (err_clr_c) begin
            err_cnt_q <= '0;
        end else if (err_inc_c && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end
`else
    assign local_hit_c = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        req_out_d   = 1'b0;
        ack_out_d   = 1'b0;
        rw_out_d    = 1'b0;
        addr_out_d  = '0;
        data_out_d  = '0;
        src_out_d   = '0;
        in_prog_d   = in_prog_q;
        abort_d     = 1'b0;
        held_req_d  = held_req_q;
        held_rw_d   = held_rw_q;
        held_addr_d = held_addr_q;
        held_data_d = held_data_q;
        held_src_d  = held_src_q;
        tmo_cnt_d   = tmo_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (fwd_hit_c) begin
                    state_d     = ST_WAIT;
                    in_prog_d   = 1'b1;
                    held_req_d  = reg_req_in;
                    held_rw_d   = reg_rd_wr_L_in;
                    held_addr_d = reg_addr_in;
                    held_data_d = reg_data_in;
                    held_src_d  = reg_src_in;
                    tmo_cnt_d   = '0;
                end else begin
                    req_out_d  = reg_req_in;
                    ack_out_d  = reg_ack_in || (reg_req_in && tag_hit_c);
                    rw_out_d   = reg_rd_wr_L_in;
                    addr_out_d = reg_addr_in;
                    src_out_d  = reg_src_in;
                    data_out_d = bad_hit_c ? ERR_DATA : reg_data_in;
`ifdef REG_RING_IFACE_ERR_CNT_EN
                    if (local_hit_c && reg_rd_wr_L_in) begin
                        data_out_d = DW'(err_cnt_q);
                    end
`endif
                end
            end
            ST_WAIT: begin
                // Ring inputs are dropped while a request is held; result_ready beats the timeout
                if (result_ready || tmo_hit_c) begin
                    state_d    = ST_IDLE;
                    in_prog_d  = 1'b0;
                    req_out_d  = held_req_q;
                    ack_out_d  = held_req_q;
                    rw_out_d   = held_rw_q;
                    addr_out_d = held_addr_q;
                    src_out_d  = held_src_q;
                    data_out_d = result_ready ? reg_result : ERR_DATA;
                    abort_d    = !result_ready;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            req_out_q   <= 1'b0;
            ack_out_q   <= 1'b0;
            rw_out_q    <= 1'b0;
            addr_out_q  <= '0;
            data_out_q  <= '0;
            src_out_q   <= '0;
            in_prog_q   <= 1'b0;
            abort_q     <= 1'b0;
            held_req_q  <= 1'b0;
            held_rw_q   <= 1'b0;
            held_addr_q <= '0;
            held_data_q <= '0;
            held_src_q  <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            req_out_q   <= req_out_d;
            ack_out_q   <= ack_out_d;
            rw_out_q    <= rw_out_d;
            addr_out_q  <= addr_out_d;
            data_out_q  <= data_out_d;
            src_out_q   <= src_out_d;
            in_prog_q   <= in_prog_d;
            abort_q     <= abort_d;
            held_req_q  <= held_req_d;
            held_rw_q   <= held_rw_d;
            held_addr_q <= held_addr_d;
            held_data_q <= held_data_d;
            held_src_q  <= held_src_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign reg_req_out      = req_out_q;
    assign reg_ack_out      = ack_out_q;
    assign reg_rd_wr_L_out  = rw_out_q;
    assign reg_addr_out     = addr_out_q;
    assign reg_data_out     = data_out_q;
    assign reg_src_out      = src_out_q;
    assign req_in_progress  = in_prog_q;
    assign req_abort        = abort_q;
    assign reg_rd_wr_L_held = held_rw_q;
    assign reg_data_held    = held_data_q;
    assign addr             = ADDR_WIDTH'(held_addr_q[INST_REG_ADDR_WIDTH-1:0]);
    assign inst_addr        = INST_WIDTH'(held_addr_q[BLOCK_ADDR_WIDTH-1:INST_REG_ADDR_WIDTH]);

endmodule

// File: tb/tb_reg_ring_inst_iface.sv
// Randomized self-checking bench for reg_ring_inst_iface with a transaction-level expectation model.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif
`timescale 1ns/1ps

module tb_reg_ring_inst_iface;

    localparam int unsigned AW     = `UDP_REG_ADDR_WIDTH;
    localparam int unsigned DW     = `CPCI_NF2_DATA_WIDTH;
    localparam int unsigned TAG_W  = AW - 17;
    localparam int unsigned T      = 16;
    localparam int unsigned NREGS  = 17;
    localparam int unsigned NINST  = 8;
    localparam logic [31:0] ERR    = 32'hdead_beef;
`ifdef REG_RING_IFACE_ERR_CNT_EN
    localparam int unsigned HIT_MAX = NREGS - 2;
`else
    localparam int unsigned HIT_MAX = NREGS - 1;
`endif

    logic          clk, reset;
    logic          reg_req_in, reg_ack_in, reg_rd_wr_L_in;
    logic [AW-1:0] reg_addr_in;
    logic [DW-1:0] reg_data_in;
    logic [1:0]    reg_src_in;
    logic          reg_req_out, reg_ack_out, reg_rd_wr_L_out;
    logic [AW-1:0] reg_addr_out;
    logic [DW-1:0] reg_data_out;
    logic [1:0]    reg_src_out;
    logic          req_in_progress, reg_rd_wr_L_held, req_abort, result_ready;
    logic [DW-1:0] reg_data_held, reg_result;
    logic [4:0]    addr;
    logic [2:0]    inst_addr;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned exp_err  = 0;

    reg_ring_inst_iface #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
        .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
        .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
        .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
        .req_in_progress(req_in_progress), .reg_rd_wr_L_held(reg_rd_wr_L_held),
        .reg_data_held(reg_data_held), .addr(addr), .inst_addr(inst_addr),
        .result_ready(result_ready), .reg_result(reg_result), .req_abort(req_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [AW-1:0] mk_addr(input int unsigned tag, input int unsigned inst,
                                              input int unsigned rg);
        return {TAG_W'(tag), 9'(inst), 8'(rg)};
    endfunction

    task automatic drive(input logic req, input logic ack, input logic rw, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [1:0] s);
        reg_req_in = req; reg_ack_in = ack; reg_rd_wr_L_in = rw;
        reg_addr_in = a; reg_data_in = d; reg_src_in = s;
    endtask

    task automatic drive_random();
        drive(1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom), $urandom, 2'($urandom));
    endtask

    task automatic check_ring(input string tag, input logic req, input logic ack, input logic rw,
                              input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] s);
        check({tag, ".req"},  64'(reg_req_out), 64'(req));
        check({tag, ".ack"},  64'(reg_ack_out), 64'(ack));
        check({tag, ".rw"},   64'(reg_rd_wr_L_out), 64'(rw));
        check({tag, ".addr"}, 64'(reg_addr_out), 64'(a));
        check({tag, ".data"}, 64'(reg_data_out), 64'(d));
        check({tag, ".src"},  64'(reg_src_out), 64'(s));
    endtask

    task automatic check_busy(input int unsigned inst, input int unsigned rg, input logic rw,
                              input logic [DW-1:0] d);
        check("busy.ring_zero", 64'({reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out,
                                      reg_data_out, reg_src_out}), 64'(0));
        check("busy.in_prog", 64'(req_in_progress), 64'(1));
        check("busy.abort", 64'(req_abort), 64'(0));
        check("busy.addr", 64'(addr), 64'(rg));
        check("busy.inst", 64'(inst_addr), 64'(inst));
        check("busy.rw", 64'(reg_rd_wr_L_held), 64'(rw));
        check("busy.data", 64'(reg_data_held), 64'(d));
    endtask

    // Non-hit traffic: outputs are the inputs one cycle later; stray result_ready is ignored
    task automatic sc_pass(input logic req, input logic ack, input logic rw, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [1:0] s);
        drive(req, ack, rw, a, d, s);
        result_ready = 1'($urandom); reg_result = $urandom;
        @(negedge clk);
        check_ring("pass", req, ack, rw, a, d, s);
        check("pass.in_prog", 64'(req_in_progress), 64'(0));
        check("pass.abort", 64'(req_abort), 64'(0));
    endtask

    task automatic sc_bad(input logic ack, input logic rw, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [1:0] s);
        drive(1'b1, ack, rw, a, d, s);
        result_ready = 1'b0;
        @(negedge clk);
        check_ring("bad", 1'b1, 1'b1, rw, a, ERR, s);
        check("bad.in_prog", 64'(req_in_progress), 64'(0));
        exp_err = (exp_err < 65535) ? exp_err + 1 : exp_err;
    endtask

    // Good hit answered k cycles later; k > T means the SM never answers
    task automatic sc_hit(input int unsigned inst, input int unsigned rg, input logic rw,
                          input logic [DW-1:0] d, input logic [1:0] s, input int unsigned k,
                          input logic [DW-1:0] res);
        logic [AW-1:0] a;
        int unsigned   last;
        a = mk_addr(0, inst, rg);
        drive(1'b1, 1'b0, rw, a, d, s);
        result_ready = 1'b0;
        @(negedge clk);
        check_busy(inst, rg, rw, d);
        last = (k <= T) ? k : T;
        for (int j = 1; j < int'(last); j++) begin
            drive_random();
            result_ready = 1'b0; reg_result = $urandom;
            @(negedge clk);
            check_busy(inst, rg, rw, d);
        end
        drive_random();
        result_ready = (k <= T); reg_result = (k <= T) ? res : $urandom;
        @(negedge clk);
        check_ring("resp", 1'b1, 1'b1, rw, a, (k <= T) ? res : ERR, s);
        check("resp.in_prog", 64'(req_in_progress), 64'(0));
        check("resp.abort", 64'(req_abort), 64'(k > T));
        if (k > T) exp_err = (exp_err < 65535) ? exp_err + 1 : exp_err;
        result_ready = 1'b0;
    endtask

    task automatic sc_reset_wait(input int unsigned inst, input int unsigned rg);
        drive(1'b1, 1'b0, 1'b1, mk_addr(0, inst, rg), $urandom, 2'($urandom));
        result_ready = 1'b0;
        for (int j = 0; j < 3; j++) @(negedge clk);
        check("rstw.in_prog_before", 64'(req_in_progress), 64'(1));
        reset = 1'b0;
        drive_random();
        @(negedge clk);
        check("rstw.ring_zero", 64'({reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out,
                                      reg_data_out, reg_src_out}), 64'(0));
        check("rstw.in_prog", 64'(req_in_progress), 64'(0));
        check("rstw.abort", 64'(req_abort), 64'(0));
        check("rstw.held", 64'({reg_data_held, addr, inst_addr, reg_rd_wr_L_held}), 64'(0));
        reset = 1'b1;
        exp_err = 0;
    endtask

`ifdef REG_RING_IFACE_ERR_CNT_EN
    task automatic sc_local(input logic rw, input logic [DW-1:0] d);
        logic [AW-1:0] a;
        a = mk_addr(0, $urandom_range(0, NINST - 1), NREGS - 1);
        drive(1'b1, 1'b0, rw, a, d, 2'($urandom));
        result_ready = 1'b0;
        @(negedge clk);
        check("local.ack", 64'(reg_ack_out), 64'(1));
        check("local.data", 64'(reg_data_out), rw ? 64'(exp_err) : 64'(d));
        check("local.in_prog", 64'(req_in_progress), 64'(0));
        if (!rw) exp_err = 0;
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        result_ready = 1'b0; reg_result = '0;
        repeat (2) @(negedge clk);
        check("reset.ring_zero", 64'({reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out,
                                       reg_data_out, reg_src_out}), 64'(0));
        check("reset.in_prog", 64'(req_in_progress), 64'(0));
        check("reset.abort", 64'(req_abort), 64'(0));
        check("reset.held", 64'({reg_data_held, addr, inst_addr, reg_rd_wr_L_held}), 64'(0));
        reset = 1'b1;

        sc_pass(1'b1, 1'b0, 1'b1, mk_addr(5, 1, 2), 32'h1234, 2'd1);
        sc_bad(1'b0, 1'b1, mk_addr(0, 0, NREGS), $urandom, 2'd2);
        sc_hit(3, 2, 1'b1, 32'h0, 2'd3, 5, 32'hCAFE_0001);
        sc_hit(1, 4, 1'b0, 32'h55AA_0F0F, 2'd0, T + 1, '0);
        sc_hit(7, 16 <= HIT_MAX ? 16 : 0, 1'b1, 32'h0, 2'd1, T, 32'h0BAD_F00D);
        sc_reset_wait(2, 9);
        sc_hit(0, 0, 1'b1, 32'h0, 2'd2, 1, 32'h1357_9BDF);

        for (int it = 0; it < 300; it++) begin
            int unsigned kind;
            kind = $urandom_range(0, 9);
            if (kind <= 3) begin
                logic req;
                req = 1'($urandom);
                sc_pass(req, 1'($urandom), 1'($urandom),
                        mk_addr(req ? $urandom_range(1, 63) : $urandom_range(0, 63),
                                $urandom_range(0, 511), $urandom_range(0, 255)),
                        $urandom, 2'($urandom));
            end else if (kind <= 5) begin
                logic [AW-1:0] a;
                if ($urandom_range(0, 1) == 0)
                    a = mk_addr(0, $urandom_range(0, 511), $urandom_range(NREGS, 255));
                else
                    a = mk_addr(0, $urandom_range(NINST, 511), $urandom_range(0, NREGS - 1));
                sc_bad(1'($urandom), 1'($urandom), a, $urandom, 2'($urandom));
            end else if (kind <= 8) begin
                sc_hit($urandom_range(0, NINST - 1), $urandom_range(0, HIT_MAX), 1'($urandom),
                       $urandom, 2'($urandom), $urandom_range(1, T + 4), $urandom);
            end else begin
                sc_reset_wait($urandom_range(0, NINST - 1), $urandom_range(0, HIT_MAX));
            end
        end

`ifdef REG_RING_IFACE_ERR_CNT_EN
        sc_reset_wait(0, 0);
        sc_bad(1'b0, 1'b1, mk_addr(0, 0, NREGS), $urandom, 2'd0);
        sc_hit(1, 1, 1'b1, 32'h0, 2'd0, T + 1, '0);
        sc_local(1'b1, 32'h0);
        sc_local(1'b0, 32'h5555_AAAA);
        sc_local(1'b1, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
